// File: rtl/acumulador_credito_pkg.sv
// Shared definitions for the credit accumulator: coin codes, FSM states and
// the default unit value of each coin.
package acumulador_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_C1   = 2'b01;
  localparam logic [1:0] COIN_C2   = 2'b10;
  localparam logic [1:0] COIN_C3   = 2'b11;

  localparam int DEF_VAL_C1 = 1;
  localparam int DEF_VAL_C2 = 2;
  localparam int DEF_VAL_C3 = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

endpackage

// File: rtl/acumulador_credito_temporizador.sv
// Inactivity down-counter. expired is high during the cycle in which the
// TIMEOUT_CYCLES-th consecutive idle edge will occur.
module temporizador_inatividade #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Loaded with T-1 so that reaching zero marks the last idle cycle.
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= LOAD_VAL;
    end else if (clear) begin
      count_q <= LOAD_VAL;
    end else if (enable && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expired = enable && (count_q == '0);

endmodule

// File: rtl/acumulador_credito.sv
// Credit accumulator: sums coins up to a cap, settles purchases against a
// price with change, and refunds everything after an inactivity timeout.
module acumulador_credito
  import acumulador_pkg::*;
#(
  parameter int CREDIT_W       = 6,
  parameter int MAX_CREDIT     = 8,
  parameter int VAL_C1         = DEF_VAL_C1,
  parameter int VAL_C2         = DEF_VAL_C2,
  parameter int VAL_C3         = DEF_VAL_C3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [1:0]          coin_code,
  input  logic                vend_req,
  input  logic [CREDIT_W-1:0] price,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_accept,
  output logic                coin_reject,
  output logic                vend_ok,
  output logic                vend_deny,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change,
  output logic                timeout_refund,
  output state_t              state_dbg
);

  // Handshake: every input is a one-cycle strobe with no ready; every
  // response is a registered one-cycle pulse the cycle after the strobe.

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] pend_q, pend_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic                accept_q, accept_d, reject_q, reject_d;
  logic                ok_q, ok_d, deny_q, deny_d;
  logic                cv_q, cv_d, refund_q, refund_d;

  logic [CREDIT_W:0]   coin_val, coin_sum;
  logic                coin_fits, expired, tmr_clear, tmr_enable;

  always_comb begin
    coin_val = '0;
    case (coin_code)
      COIN_C1: coin_val = (CREDIT_W+1)'(VAL_C1);
      COIN_C2: coin_val = (CREDIT_W+1)'(VAL_C2);
      COIN_C3: coin_val = (CREDIT_W+1)'(VAL_C3);
      default: coin_val = '0;
    endcase
  end

  // One extra bit so an oversized insert is rejected instead of wrapping.
  assign coin_sum  = {1'b0, credit_q} + coin_val;
  assign coin_fits = (coin_code != COIN_NONE) &&
                     (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));

  assign tmr_enable = (state_q == ST_ACCUM);
  assign tmr_clear  = coin_valid || vend_req || (state_q != ST_ACCUM);

  temporizador_inatividade #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .expired(expired)
  );

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    pend_d   = pend_q;
    change_d = change_q;
    accept_d = 1'b0;
    reject_d = 1'b0;
    ok_d     = 1'b0;
    deny_d   = 1'b0;
    cv_d     = 1'b0;
    refund_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        // A vend takes precedence; a coin in the same cycle is returned.
        if (vend_req) begin
          reject_d = coin_valid;
          if ((state_q == ST_ACCUM) && (credit_q >= price)) begin
            ok_d    = 1'b1;
            pend_d  = credit_q - price;
            state_d = ST_SETTLE;
          end else begin
            deny_d = 1'b1;
          end
        end else if (coin_valid) begin
          if (coin_fits) begin
            accept_d = 1'b1;
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = ST_ACCUM;
          end else begin
            reject_d = 1'b1;
          end
        end else if ((state_q == ST_ACCUM) && expired) begin
          refund_d = 1'b1;
          pend_d   = credit_q;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        cv_d     = 1'b1;
        change_d = pend_q;
        credit_d = '0;
        reject_d = coin_valid;
        deny_d   = vend_req;
        state_d  = ST_IDLE;
      end
      default: begin
        credit_d = '0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      pend_q   <= '0;
      change_q <= '0;
      accept_q <= 1'b0;
      reject_q <= 1'b0;
      ok_q     <= 1'b0;
      deny_q   <= 1'b0;
      cv_q     <= 1'b0;
      refund_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      pend_q   <= pend_d;
      change_q <= change_d;
      accept_q <= accept_d;
      reject_q <= reject_d;
      ok_q     <= ok_d;
      deny_q   <= deny_d;
      cv_q     <= cv_d;
      refund_q <= refund_d;
    end
  end

  assign credit         = credit_q;
  assign coin_accept    = accept_q;
  assign coin_reject    = reject_q;
  assign vend_ok        = ok_q;
  assign vend_deny      = deny_q;
  assign change_valid   = cv_q;
  assign change         = change_q;
  assign timeout_refund = refund_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_acumulador_credito.sv
// Directed bench for acumulador_credito with a 10-cycle timeout and the
// default 2,00 cap; expected values are hand-computed per step.
module tb_acumulador_credito;
  import acumulador_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       coin_valid;
  logic [1:0] coin_code;
  logic       vend_req;
  logic [5:0] price;
  logic [5:0] credit;
  logic       coin_accept, coin_reject, vend_ok, vend_deny;
  logic       change_valid, timeout_refund;
  logic [5:0] change;
  state_t     state_dbg;

  int checks = 0;
  int errors = 0;

  acumulador_credito #(
    .CREDIT_W(6), .MAX_CREDIT(8), .VAL_C1(1), .VAL_C2(2), .VAL_C3(4),
    .TIMEOUT_CYCLES(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_code(coin_code),
    .vend_req(vend_req), .price(price), .credit(credit),
    .coin_accept(coin_accept), .coin_reject(coin_reject), .vend_ok(vend_ok),
    .vend_deny(vend_deny), .change_valid(change_valid), .change(change),
    .timeout_refund(timeout_refund), .state_dbg(state_dbg)
  );

  // clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int cr, input state_t st,
                            input bit acc, input bit rej, input bit ok, input bit dny,
                            input bit cv, input int ch, input bit rf);
    chk({tag, ".credit"},  32'(credit),         32'(cr));
    chk({tag, ".state"},   32'(state_dbg),      32'(st));
    chk({tag, ".accept"},  32'(coin_accept),    32'(acc));
    chk({tag, ".reject"},  32'(coin_reject),    32'(rej));
    chk({tag, ".vend_ok"}, 32'(vend_ok),        32'(ok));
    chk({tag, ".deny"},    32'(vend_deny),      32'(dny));
    chk({tag, ".cvalid"},  32'(change_valid),   32'(cv));
    chk({tag, ".change"},  32'(change),         32'(ch));
    chk({tag, ".refund"},  32'(timeout_refund), 32'(rf));
  endtask

  // driver: apply one cycle of inputs, return at posedge+1 with inputs idle
  task automatic tick(input logic cv, input logic [1:0] code, input logic vr,
                      input logic [5:0] pr);
    coin_valid = cv;
    coin_code  = code;
    vend_req   = vr;
    price      = pr;
    @(posedge clk);
    #1;
    coin_valid = 1'b0;
    coin_code  = COIN_NONE;
    vend_req   = 1'b0;
    price      = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(0, COIN_NONE, 0, 0);
    tick(0, COIN_NONE, 0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; coin_valid = 1'b0; coin_code = COIN_NONE; vend_req = 1'b0; price = '0;
    @(posedge clk); #1;
    do_reset();
    expect_out("reset", 0, ST_IDLE, 0, 0, 0, 0, 0, 0, 0);

    // consecutive C1, C2, C3
    tick(1, COIN_C1, 0, 0); expect_out("c1", 1, ST_ACCUM, 1, 0, 0, 0, 0, 0, 0);
    tick(1, COIN_C2, 0, 0); expect_out("c2", 3, ST_ACCUM, 1, 0, 0, 0, 0, 0, 0);
    tick(1, COIN_C3, 0, 0); expect_out("c3", 7, ST_ACCUM, 1, 0, 0, 0, 0, 0, 0);

    // cap handling
    tick(1, COIN_C2, 0, 0);   expect_out("over_cap", 7, ST_ACCUM, 0, 1, 0, 0, 0, 0, 0);
    tick(1, COIN_C1, 0, 0);   expect_out("to_cap",   8, ST_ACCUM, 1, 0, 0, 0, 0, 0, 0);
    tick(1, COIN_C1, 0, 0);   expect_out("at_cap",   8, ST_ACCUM, 0, 1, 0, 0, 0, 0, 0);
    tick(1, COIN_NONE, 0, 0); expect_out("code00",   8, ST_ACCUM, 0, 1, 0, 0, 0, 0, 0);

    // sale 6 - 5 = 1
    do_reset();
    tick(1, COIN_C2, 0, 0); tick(1, COIN_C3, 0, 0);
    expect_out("credit6", 6, ST_ACCUM, 1, 0, 0, 0, 0, 0, 0);
    tick(0, COIN_NONE, 1, 6'd5); expect_out("sale_t1", 6, ST_SETTLE, 0, 0, 1, 0, 0, 0, 0);
    tick(0, COIN_NONE, 0, 0);    expect_out("sale_t2", 0, ST_IDLE,   0, 0, 0, 0, 1, 1, 0);
    tick(0, COIN_NONE, 0, 0);    expect_out("sale_t3", 0, ST_IDLE,   0, 0, 0, 0, 0, 1, 0);

    // denials
    tick(0, COIN_NONE, 1, 6'd0); expect_out("idle_vend0", 0, ST_IDLE, 0, 0, 0, 1, 0, 1, 0);
    tick(1, COIN_C1, 0, 0); tick(1, COIN_C2, 0, 0);
    tick(0, COIN_NONE, 1, 6'd4); expect_out("deny_3_4", 3, ST_ACCUM, 0, 0, 0, 1, 0, 1, 0);
    tick(1, COIN_C1, 1, 6'd4);   expect_out("vend_coin", 3, ST_ACCUM, 0, 1, 0, 1, 0, 1, 0);
    tick(0, COIN_NONE, 1, 6'd3); expect_out("exact_t1", 3, ST_SETTLE, 0, 0, 1, 0, 0, 1, 0);
    tick(1, COIN_C1, 1, 6'd1);   expect_out("exact_t2", 0, ST_IDLE,   0, 1, 0, 1, 1, 0, 0);

    // timeout refund of 5 after 10 idle cycles
    do_reset();
    tick(1, COIN_C1, 0, 0); tick(1, COIN_C3, 0, 0);
    expect_out("credit5", 5, ST_ACCUM, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      tick(0, COIN_NONE, 0, 0);
      chk($sformatf("to_idle%0d.refund", i), 32'(timeout_refund), 32'd0);
    end
    tick(0, COIN_NONE, 0, 0); expect_out("to_fire",   5, ST_SETTLE, 0, 0, 0, 0, 0, 0, 1);
    tick(0, COIN_NONE, 0, 0); expect_out("to_settle", 0, ST_IDLE,   0, 0, 0, 0, 1, 5, 0);

    // a coin on the would-be expiry cycle restarts the count
    tick(1, COIN_C1, 0, 0); expect_out("rs_c1", 1, ST_ACCUM, 1, 0, 0, 0, 0, 5, 0);
    for (int i = 1; i <= 9; i++) begin
      tick(0, COIN_NONE, 0, 0);
      chk($sformatf("rs_idle%0d.refund", i), 32'(timeout_refund), 32'd0);
    end
    tick(1, COIN_C1, 0, 0); expect_out("rs_coin", 2, ST_ACCUM, 1, 0, 0, 0, 0, 5, 0);
    for (int i = 1; i <= 9; i++) begin
      tick(0, COIN_NONE, 0, 0);
      chk($sformatf("rs2_idle%0d.refund", i), 32'(timeout_refund), 32'd0);
    end
    tick(0, COIN_NONE, 0, 0); expect_out("rs_fire",   2, ST_SETTLE, 0, 0, 0, 0, 0, 5, 1);
    tick(0, COIN_NONE, 0, 0); expect_out("rs_settle", 0, ST_IDLE,   0, 0, 0, 0, 1, 2, 0);

    // reset in SETTLE aborts the sale
    tick(1, COIN_C2, 0, 0);
    tick(0, COIN_NONE, 1, 6'd1); expect_out("ab_ok", 2, ST_SETTLE, 0, 0, 1, 0, 0, 2, 0);
    rst_n = 1'b0;
    #1;
    expect_out("ab_rst", 0, ST_IDLE, 0, 0, 0, 0, 0, 0, 0);
    tick(0, COIN_NONE, 0, 0);
    rst_n = 1'b1;
    tick(0, COIN_NONE, 0, 0); expect_out("ab_rel1", 0, ST_IDLE, 0, 0, 0, 0, 0, 0, 0);
    tick(0, COIN_NONE, 0, 0); expect_out("ab_rel2", 0, ST_IDLE, 0, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acumulador_credito.md
# acumulador_credito

Parametrised credit accumulator for the vending machine datapath; successor to the fixed 0,00–2,00 accumulator FSM. Sums coin inserts in units of 0,25, rejects coins that would exceed the cap instead of silently resetting, runs its own inactivity timeout with full refund, and settles a purchase against a price input with change output. It sits between the coin-slot decoder (upstream) and the product/change dispensers (downstream).

## Interface
- `CREDIT_W`, default 6: credit register width, in units of 0,25.
- `MAX_CREDIT`, default 8: credit cap in units (8 = 2,00). Must be ≤ 2^CREDIT_W−1.
- `VAL_C1` / `VAL_C2` / `VAL_C3`, default 1 / 2 / 4: unit values for coin codes 01 / 10 / 11.
- `TIMEOUT_CYCLES`, default 1000: idle cycles with nonzero credit before an automatic refund.
- `clk`, input, 1: system clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `coin_valid`, input, 1: one-cycle strobe; a coin is present on `coin_code`.
- `coin_code`, input, 2: 00 = none/invalid, 01/10/11 = C1/C2/C3.
- `vend_req`, input, 1: one-cycle purchase request.
- `price`, input, CREDIT_W: item price in units; sampled with `vend_req`.
- `credit`, output, CREDIT_W: current accumulated credit.
- `coin_accept`, output, 1: one-cycle pulse; coin added.
- `coin_reject`, output, 1: one-cycle pulse; coin returned (code 00 or cap exceeded).
- `vend_ok`, output, 1: one-cycle pulse; purchase granted.
- `vend_deny`, output, 1: one-cycle pulse; credit < price.
- `change_valid`, output, 1: one-cycle pulse qualifying `change`.
- `change`, output, CREDIT_W: units to return (on a sale or a refund).
- `timeout_refund`, output, 1: one-cycle pulse; inactivity refund issued.

## Operation
- States: IDLE (credit = 0), ACCUM (credit > 0), SETTLE (one cycle, emits sale or refund).
- Coin: value v = VAL_Cx. If credit + v ≤ MAX_CREDIT: credit += v, `coin_accept`. Otherwise credit is unchanged and `coin_reject`. Code 00 with `coin_valid` also gives `coin_reject`. Compute the sum at CREDIT_W+1 bits; never wraps.
- Vend in ACCUM: if credit ≥ price, `vend_ok` and go to SETTLE with change = credit − price; else `vend_deny` with credit unchanged. Vend in IDLE gives `vend_deny` (price 0 included).
- SETTLE: `change_valid` with `change`; credit := 0; next state IDLE.
- Timeout: an idle counter runs in ACCUM and clears on any `coin_valid` or `vend_req`. At TIMEOUT_CYCLES, `timeout_refund` fires and the FSM goes to SETTLE with change = credit.
- Simultaneous `coin_valid` and `vend_req`: the vend is processed first, against the pre-coin credit, and the coin is rejected. The same applies in SETTLE: any coin is rejected and any vend is denied.
- Timeout coinciding with `coin_valid`/`vend_req`: the input wins and the counter clears.
- Reset (asynchronous, any state): credit 0, state IDLE, counter 0, all pulse outputs 0, `change` 0. An in-flight sale is aborted with no change pulse.

## Timing
- All outputs are registered. A response pulse appears the cycle after the input strobe.
- `credit` reflects an accepted coin 1 cycle after `coin_valid`.
- Sale: `vend_req` at cycle t → `vend_ok` at t+1 → `change_valid` and credit = 0 at t+2.
- Timeout: `timeout_refund` is asserted TIMEOUT_CYCLES cycles after the last activity, with `change_valid` one cycle later.
- `change` holds its value until the next `change_valid`.
- Back-to-back coins are accepted every cycle.

## Structure
- Package `acumulador_pkg`: coin code constants (COIN_NONE, COIN_C1..C3), state enum, default unit values.
- Sub-module `temporizador_inatividade`: parametrised down-counter with `clear`/`enable`/`expired`, clog2(TIMEOUT_CYCLES+1) bits wide.

## Test plan
- Reset, then C1, C2, C3 on consecutive cycles → credit 1, 3, 7; three `coin_accept` pulses.
- Credit 7, insert C2 → `coin_reject`, credit stays 7. Then C1 → credit 8.
- Credit 6, `vend_req` with price 5 → `vend_ok` at t+1; `change_valid` with change = 1 and credit 0 at t+2.
- Credit 3, price 4 → `vend_deny`, credit 3. Then `vend_req` and `coin_valid` C1 in the same cycle → `vend_deny` and `coin_reject`.
- TIMEOUT_CYCLES = 10, credit 5, no activity → `timeout_refund` after 10 cycles, then change = 5 and credit 0. Inserting a coin at cycle 9 restarts the count.
- Assert `rst_n` low during SETTLE → all outputs 0 immediately, no `change_valid` after release.
